// File: rtl/lab2_logic_unit_if.sv
// Operand/result handshake bundle for lab2_logic_unit.
// The slave modport is the unit; master is the producer/consumer side.
interface lab2_logic_unit_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             acc_mode;
    logic             acc_clear;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             y_any;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, a, b, op, acc_mode, acc_clear, out_ready,
        input  in_ready, out_valid, y, y_any, op_count
    );

    modport slave (
        input  in_valid, a, b, op, acc_mode, acc_clear, out_ready,
        output in_ready, out_valid, y, y_any, op_count
    );
endinterface

// File: rtl/lab2_logic_unit.sv
// Registered W-bit bitwise logic unit (OR/AND/XOR/NOR) with valid/ready on both sides.
// Define LAB2_LOGIC_ACC_EN to build the accumulator and accumulate mode.
module lab2_logic_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    lab2_logic_unit_if.slave  bus
);
    typedef enum logic {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_any_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result;
    logic             in_fire;
    logic             out_fire;

    function automatic logic [WIDTH-1:0] apply_op(input logic [1:0]       sel,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] z);
        logic [WIDTH-1:0] r;
        case (sel)
            2'b00:   r = x | z;
            2'b01:   r = x & z;
            2'b10:   r = x ^ z;
            default: r = ~(x | z);
        endcase
        return r;
    endfunction

    assign bus.out_valid = (state_q == StFull);
    assign bus.in_ready  = !bus.out_valid || bus.out_ready;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign out_fire      = bus.out_valid && bus.out_ready;

`ifdef LAB2_LOGIC_ACC_EN
    logic [WIDTH-1:0] acc_q;

    always_comb begin
        result = '0;
        if (bus.acc_mode) begin
            result = bus.acc_clear ? bus.a : apply_op(bus.op, acc_q, bus.a);
        end else begin
            result = apply_op(bus.op, bus.a, bus.b);
        end
    end

    // Normal-mode results also seed the accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (in_fire) begin
            acc_q <= result;
        end
    end
`else
    logic unused_acc;
    assign unused_acc = bus.acc_mode ^ bus.acc_clear;
    assign result     = apply_op(bus.op, bus.a, bus.b);
`endif

    // Output register: in FULL an input fire implies out_ready, so load covers drain+refill.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    state_d = StFull;
                    y_d     = result;
                end
            end
            StFull: begin
                if (in_fire) begin
                    y_d = result;
                end else if (out_fire) begin
                    state_d = StEmpty;
                end
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (in_fire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            y_q     <= '0;
            y_any_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            y_any_q <= |y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.y        = y_q;
    assign bus.y_any    = y_any_q;
    assign bus.op_count = cnt_q;
endmodule

// File: tb/tb_lab2_logic_unit.sv
// Directed bench for lab2_logic_unit: two instances (CNT_W=8 and CNT_W=2) share stimulus.
// Accumulate expectations follow the LAB2_LOGIC_ACC_EN build setting.
module tb_lab2_logic_unit;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    lab2_logic_unit_if #(.WIDTH(8), .CNT_W(8)) bus ();
    lab2_logic_unit_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

    lab2_logic_unit #(.WIDTH(8), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    lab2_logic_unit #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.a         = bus.a;
    assign bus2.b         = bus.b;
    assign bus2.op        = bus.op;
    assign bus2.acc_mode  = bus.acc_mode;
    assign bus2.acc_clear = bus.acc_clear;
    assign bus2.out_ready = bus.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_ops  [4];
    logic [7:0] acc_in   [4];
    logic [7:0] acc_exp  [4];
    logic [1:0] sat_exp  [6];

    initial begin
        vectors      = 0;
        miscompares  = 0;
        exp_ops      = '{8'hEE, 8'h88, 8'h66, 8'h11};
        acc_in       = '{8'h01, 8'h02, 8'h04, 8'h08};
`ifdef LAB2_LOGIC_ACC_EN
        acc_exp      = '{8'h01, 8'h03, 8'h07, 8'h0F};
`else
        acc_exp      = '{8'h01, 8'h02, 8'h04, 8'h08};
`endif
        sat_exp      = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.op        = 2'b00;
        bus.acc_mode  = 1'b0;
        bus.acc_clear = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_y", 32'(bus.y), 32'h00);
        check("rst_y_any", 32'(bus.y_any), 32'd0);
        check("rst_op_count", 32'(bus.op_count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // First OR beat
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 8'h0F;
        bus.b        = 8'hF0;
        bus.op       = 2'b00;
        step();
        check("or_y", 32'(bus.y), 32'hFF);
        check("or_y_any", 32'(bus.y_any), 32'd1);
        check("or_out_valid", 32'(bus.out_valid), 32'd1);
        check("or_op_count", 32'(bus.op_count), 32'd1);

        // All four ops back to back
        bus.a = 8'hCC;
        bus.b = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            bus.op = 2'(i);
            step();
            check($sformatf("op%0d_y", i), 32'(bus.y), 32'(exp_ops[i]));
            check($sformatf("op%0d_y_any", i), 32'(bus.y_any), 32'd1);
        end
        check("ops_op_count", 32'(bus.op_count), 32'd5);

        // Mid-stream reset while FULL with a beat offered
        rst_n = 1'b0;
        step();
        check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_y", 32'(bus.y), 32'h00);
        check("mrst_y_any", 32'(bus.y_any), 32'd0);
        check("mrst_op_count", 32'(bus.op_count), 32'd0);
        check("mrst_in_ready", 32'(bus.in_ready), 32'd1);

        // Backpressure: first beat lands, later offers are ignored
        rst_n         = 1'b1;
        bus.out_ready = 1'b0;
        bus.a         = 8'h33;
        bus.b         = 8'h0F;
        bus.op        = 2'b10;
        step();
        check("bp_first_y", 32'(bus.y), 32'h3C);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.a = 8'h55;
        for (int i = 0; i < 4; i++) step();
        check("bp_hold_y", 32'(bus.y), 32'h3C);
        check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        check("bp_op_count", 32'(bus.op_count), 32'd1);
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_comb", 32'(bus.in_ready), 32'd1);
        step();
        check("bp_refill_y", 32'(bus.y), 32'h5A);
        check("bp_refill_valid", 32'(bus.out_valid), 32'd1);
        check("bp_refill_count", 32'(bus.op_count), 32'd2);

        // Accumulate stream
        bus.acc_mode  = 1'b1;
        bus.acc_clear = 1'b1;
        bus.b         = 8'h00;
        bus.op        = 2'b00;
        for (int i = 0; i < 4; i++) begin
            bus.a = acc_in[i];
            step();
            check($sformatf("acc%0d_y", i), 32'(bus.y), 32'(acc_exp[i]));
            bus.acc_clear = 1'b0;
        end

        // Reset clears the accumulator: OR against it must return a alone
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.a = 8'h10;
        step();
        check("acc_after_rst_y", 32'(bus.y), 32'h10);

        // Counter saturation on the CNT_W=2 instance
        rst_n         = 1'b0;
        bus.acc_mode  = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.op        = 2'b00;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("sat%0d_count", i), 32'(bus2.op_count), 32'(sat_exp[i]));
        end
        check("sat_y", 32'(bus2.y), 32'h00);
        check("sat_y_any", 32'(bus2.y_any), 32'd0);
        check("wide_count", 32'(bus.op_count), 32'd6);

        bus.in_valid = 1'b0;
        step();
        check("idle_drain_valid", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
